tdc_uart_tx: RTL and testbench
==============================

# tdc_uart_tx

Transmit end for TDC timestamps: accepts each completed 24-bit TDC word (`{coarse[9:0], decodedStart[6:0], decodedStop[6:0]}`) together with its one-cycle valid strobe. It buffers words in a small FIFO and serializes each one over a UART 8N1 line as a 4-byte frame: a sync byte followed by the word, MSB byte first. The block sits beside the TDC top level, in the same clock domain, and is the only path from measurements to the host.

## Interface
Parameters:
- `DIG_OUT`, 24, TDC word width; fixed at 24 (3 payload bytes).
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; minimum 2.
- `FIFO_DEPTH`, 16, FIFO depth in words; power of two, minimum 2.
- `SYNC_BYTE`, 8'hA5, frame header byte.

Ports:
- `iClk`  in  1  system clock, same as the TDC.
- `iRst`  in  1  asynchronous, active-high reset.
- `iTDC`  in  DIG_OUT  TDC word, valid when `iValid`=1.
- `iValid`  in  1  one-cycle strobe: new word on `iTDC`.
- `oTx`  out  1  UART line; idles high.
- `oBusy`  out  1  1 while a frame is being shifted.
- `oOverflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `oLevel`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: `oTx`=1, `oBusy`=0, `oOverflow`=0, `oLevel`=0. FIFO pointers and state machine are cleared.
- **Write.** On a clock edge with `iValid`=1, `iTDC` is written when `oLevel`<FIFO_DEPTH, or when a pop occurs on the same edge.
  - Otherwise the word is dropped and `oOverflow` is set.
  - `oOverflow` is cleared only by `iRst`.
- **Frame.** Bytes are sent in this order: `SYNC_BYTE`, `iTDC[23:16]`, `iTDC[15:8]`, `iTDC[7:0]`.
  - Each byte is a start bit (0), 8 data bits LSB first, then a stop bit (1).
  - Bytes within a frame are back-to-back with no idle gap.
- **State machine** (byte index 0..3, bit index 0..7, baud counter 0..CLKS_PER_BIT-1):
  - IDLE: `oTx`=1. If the FIFO is non-empty: pop the head into the shift word, set byte index to 0, go to START.
  - START: `oTx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `oTx` = current bit, each held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `oTx`=1 for CLKS_PER_BIT cycles. If byte index <3: increment it and go to START. Otherwise go to IDLE.
- `oBusy`=1 in START, DATA and STOP.
- The shift word is captured at pop time, so later FIFO writes never corrupt a frame in flight.
- **Reset mid-frame.** The line returns high immediately and the partial frame is abandoned. All buffered words are discarded.

## Timing
- **Write latency.** A word sampled at edge N appears in `oLevel` after edge N.
- **Start latency.** With the FIFO empty and the FSM in IDLE, the pop and the start bit both take effect on edge N+1. `oTx` falls after edge N+1.
- **Frame length.** Exactly 40·CLKS_PER_BIT cycles from the first start-bit edge to the end of the final stop bit.
- **Between frames.** With the FIFO non-empty, there is exactly 1 extra idle-high cycle (the IDLE pop cycle) between frames.
- **Baud counter.** Wraps from CLKS_PER_BIT-1 to 0. A bit transition occurs on the wrap edge.
- **Occupancy on simultaneous push and pop.** `oLevel` is unchanged.
- **Sustained input rate.** Sustained input faster than one word per 40·CLKS_PER_BIT+1 cycles eventually overflows.

## Structure
- Shared package `tdc_pkg` holds the constants common with the TDC top: `DIG_OUT`=24, `COUNTER_DIG`=10, `NUM_DECODE`=7, `SYNC_BYTE`, and `FRAME_BYTES`=4.
- Sub-module `tdc_word_fifo`: synchronous FIFO with first-word-fall-through head. It takes the write strobe and pop strobe, and reports full, empty and level.
- The UART shifter and frame FSM remain in `tdc_uart_tx`.

## Test plan
- **Single word.** CLKS_PER_BIT=4; reset, then `iValid` pulse with `iTDC`=24'h123456.
  - `oTx` falls 1 cycle after the sampling edge.
  - Decoded bytes are A5, 12, 34, 56; the frame lasts 160 cycles; `oBusy` then drops and `oTx`=1.
- **Burst of 3 words.** Words 24'h000001, 24'h800000, 24'hFFFFFF on consecutive cycles.
  - `oLevel` goes 1→2→3, then falls to 2 at the first pop.
  - Three frames are sent in order, each separated by exactly one idle cycle.
- **Overflow.** FIFO_DEPTH=4; push 6 words while the first frame is in flight.
  - The first 5 words are transmitted (1 in the shifter, 4 in the FIFO).
  - The 6th word is dropped and `oOverflow`=1, held until `iRst`.
- **Push into a full FIFO on the pop edge.** `iValid` on the same edge the FSM pops while `oLevel`=FIFO_DEPTH.
  - The word is accepted, `oLevel` stays at FIFO_DEPTH, and `oOverflow` stays 0.
- **Reset mid-frame.** Assert `iRst` during DATA of byte 2.
  - `oTx`=1, `oBusy`=0 and `oLevel`=0 immediately, with no clock needed.
  - After release, a new word produces a complete, correct frame.

Source files
------------

// File: rtl/tdc_pkg.sv
// Purpose: constants and types shared between the TDC top level and its UART transmit path.
// Contents: word geometry, frame header byte, transmit FSM state type, frame byte selector.
package tdc_pkg;

    localparam int unsigned DIG_OUT     = 24;
    localparam int unsigned COUNTER_DIG = 10;
    localparam int unsigned NUM_DECODE  = 7;
    localparam int unsigned FRAME_BYTES = 4;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    // One completed TDC measurement as produced by the TDC top level.
    typedef struct packed {
        logic [COUNTER_DIG-1:0] coarse;
        logic [NUM_DECODE-1:0]  dec_start;
        logic [NUM_DECODE-1:0]  dec_stop;
    } tdc_word_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Byte idx of a frame: 0 is the header, 1..3 are the payload MSB byte first.
    function automatic logic [7:0] frame_byte(input tdc_word_t word,
                                              input logic [1:0] idx,
                                              input logic [7:0] sync);
        logic [23:0] flat;
        flat = word;
        case (idx)
            2'd0:    frame_byte = sync;
            2'd1:    frame_byte = flat[23:16];
            2'd2:    frame_byte = flat[15:8];
            default: frame_byte = flat[7:0];
        endcase
    endfunction

endpackage

// File: rtl/tdc_word_fifo.sv
// Purpose: synchronous word FIFO with first-word-fall-through head for the TDC transmit path.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    write request and word; accepted when not full or when popping on the same edge
//   rd_en             pop the head word (only honoured when not empty)
//   rd_data_c         current head word (combinational view of storage)
//   full_c, empty_c   occupancy flags (combinational from the level register)
//   level             registered occupancy, 0..DEPTH
module tdc_word_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_c;
    logic             pop_c;

    assign full_c    = (level_q == LW'(DEPTH));
    assign empty_c   = (level_q == '0);
    assign rd_data_c = mem[rd_ptr_q];
    assign level     = level_q;

    // A pop on the same edge frees the slot a full-FIFO write needs.
    assign pop_c  = rd_en && !empty_c;
    assign push_c = wr_en && (!full_c || pop_c);

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/tdc_uart_tx.sv
// Purpose: buffers TDC words and sends each as a 4-byte UART 8N1 frame (header, then word MSB byte first).
// Ports:
//   iClk, iRst   system clock, asynchronous active-high reset
//   iTDC         24-bit TDC word, valid when iValid=1
//   iValid       one-cycle strobe for iTDC
//   oTx          UART line, idles high
//   oBusy        high while a frame is being shifted
//   oOverflow    sticky flag: a word was dropped on a full FIFO
//   oLevel       FIFO occupancy
module tdc_uart_tx #(
    parameter int unsigned DIG_OUT      = tdc_pkg::DIG_OUT,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [7:0]  SYNC_BYTE    = tdc_pkg::SYNC_BYTE
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic [DIG_OUT-1:0]            iTDC,
    input  logic                          iValid,
    output logic                          oTx,
    output logic                          oBusy,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel
);

    import tdc_pkg::*;

    localparam int unsigned CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]  LAST_BYTE  = 2'(FRAME_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       sh_q, sh_d;
    tdc_word_t        word_q, word_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [DIG_OUT-1:0] head_c;
    logic               full_c;
    logic               empty_c;
    logic               pop_c;
    logic               baud_wrap_c;

    assign pop_c       = (state_q == TX_IDLE) && !empty_c;
    assign baud_wrap_c = (cnt_q == BAUD_LAST);

    tdc_word_fifo #(
        .WIDTH (DIG_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (iClk),
        .rst       (iRst),
        .wr_en     (iValid),
        .wr_data   (iTDC),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .level     (oLevel)
    );

    // Frame FSM; tx_d/busy_d describe the line during the state being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        sh_d       = sh_q;
        word_d     = word_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q | (iValid & full_c & ~pop_c);

        if (state_q != TX_IDLE) begin
            cnt_d = baud_wrap_c ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty_c) begin
                    // The word is copied out here so later FIFO writes cannot disturb this frame.
                    word_d     = tdc_word_t'(head_c);
                    byte_idx_d = 2'd0;
                    sh_d       = SYNC_BYTE;
                    cnt_d      = '0;
                    state_d    = TX_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            TX_START: begin
                if (baud_wrap_c) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                end
            end
            TX_DATA: begin
                if (baud_wrap_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (baud_wrap_c) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        sh_d       = frame_byte(word_q, byte_idx_q + 2'd1, SYNC_BYTE);
                        state_d    = TX_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            sh_q       <= '0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            sh_q       <= sh_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign oTx       = tx_q;
    assign oBusy     = busy_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_tdc_uart_tx.sv
// Bench for tdc_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A background receiver decodes every frame on oTx into a queue; the main sequence drives words and compares.
module tb_tdc_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FLEN  = 40 * CPB;

    logic        clk;
    logic        iRst;
    logic [23:0] iTDC;
    logic        iValid;
    logic        oTx;
    logic        oBusy;
    logic        oOverflow;
    logic [2:0]  oLevel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          start;
        bit          fmt_ok;
        bit          busy_ok;
        bit          end_ok;
    } frame_t;

    typedef struct {
        logic [23:0] tdc;
        logic [31:0] exp;
    } vec_t;

    frame_t frq[$];
    logic   smp [FLEN];

    tdc_uart_tx #(
        .DIG_OUT      (24),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .iClk      (clk),
        .iRst      (iRst),
        .iTDC      (iTDC),
        .iValid    (iValid),
        .oTx       (oTx),
        .oBusy     (oBusy),
        .oOverflow (oOverflow),
        .oLevel    (oLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic frame_t get_fr(input int i);
        frame_t f;
        f.data = 32'hxxxxxxxx; f.start = -1; f.fmt_ok = 0; f.busy_ok = 0; f.end_ok = 0;
        if (i < frq.size()) f = frq[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Word is sampled on the next edge; n returns that edge's cycle number.
    task automatic push(input logic [23:0] w, output int n);
        iTDC = w; iValid = 1'b1;
        tick();
        iValid = 1'b0;
        n = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (frq.size() < n && c < budget) begin tick(); c++; end
        chk("frame_wait", 32'(frq.size() >= n), 32'd1);
    endtask

    task automatic chk_frame(input string name, input int i, input logic [31:0] exp);
        frame_t f;
        f = get_fr(i);
        chk({name, "_data"}, f.data, exp);
        chk({name, "_fmt"}, {29'd0, f.fmt_ok, f.busy_ok, f.end_ok}, 32'd7);
    endtask

    // Receiver: expects exact bit timing, start 0 / 8 data LSB first / stop 1 per byte.
    initial begin : monitor
        frame_t     f;
        logic [7:0] bv;
        logic       v;
        bit         aborted;
        forever begin
            tick();
            if (!iRst && oTx === 1'b0) begin
                f.start = cyc; f.data = '0; f.fmt_ok = 1; f.busy_ok = (oBusy === 1'b1);
                aborted = 0; smp[0] = oTx; bv = '0;
                for (int i = 1; i < FLEN; i++) begin
                    tick();
                    smp[i] = oTx;
                    if (oBusy !== 1'b1) f.busy_ok = 0;
                    if (iRst) aborted = 1;
                end
                tick();
                f.end_ok = (oTx === 1'b1) && (oBusy === 1'b0);
                if (iRst) aborted = 1;
                for (int b = 0; b < 4; b++) begin
                    for (int p = 0; p < 10; p++) begin
                        v = smp[(b * 10 + p) * CPB];
                        for (int k = 1; k < CPB; k++)
                            if (smp[(b * 10 + p) * CPB + k] !== v) f.fmt_ok = 0;
                        if (p == 0 && v !== 1'b0) f.fmt_ok = 0;
                        if (p == 9 && v !== 1'b1) f.fmt_ok = 0;
                        if (p >= 1 && p <= 8) bv[p - 1] = v;
                    end
                    f.data = {f.data[23:0], bv};
                end
                if (!aborted) frq.push_back(f);
            end
        end
    end

    initial begin : main
        vec_t        vecs [4];
        logic [23:0] ovw  [6];
        logic [23:0] pw   [6];
        int          n0, n;
        frame_t      fa, fb;

        vecs[0] = '{24'h123456, 32'hA5123456};
        vecs[1] = '{24'h000001, 32'hA5000001};
        vecs[2] = '{24'h800000, 32'hA5800000};
        vecs[3] = '{24'hFFFFFF, 32'hA5FFFFFF};
        ovw = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
        pw  = '{24'hABCDEF, 24'h010203, 24'h0A0B0C, 24'h7F7F7F, 24'h00FF00, 24'h5A5A5A};

        iRst = 1'b1; iValid = 1'b0; iTDC = '0;
        repeat (3) tick();
        chk("rst_tx", 32'(oTx), 32'd1);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_ovf", 32'(oOverflow), 32'd0);
        chk("rst_level", 32'(oLevel), 32'd0);
        iRst = 1'b0;
        repeat (2) tick();

        // Single word, then a 3-word burst while its frame is in flight.
        push(vecs[0].tdc, n0);
        chk("single_level", 32'(oLevel), 32'd1);
        wait_until(n0 + 20);
        chk("single_busy", 32'(oBusy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            push(vecs[i].tdc, n);
            chk($sformatf("burst_level%0d", i), 32'(oLevel), 32'(i));
        end
        wait_until(n0 + 1 + FLEN);
        chk("burst_level_pre_pop", 32'(oLevel), 32'd3);
        tick();
        chk("burst_level_pop", 32'(oLevel), 32'd2);
        wait_frames(4, 900);
        for (int i = 0; i < 4; i++) begin
            chk_frame($sformatf("vec%0d", i), i, vecs[i].exp);
            fa = get_fr(i);
            if (i == 0) begin
                chk("start_latency", 32'(fa.start), 32'(n0 + 1));
            end else begin
                fb = get_fr(i - 1);
                chk($sformatf("gap%0d", i), 32'(fa.start - fb.start), 32'(FLEN + 1));
            end
        end
        chk("burst_ovf", 32'(oOverflow), 32'd0);
        chk("burst_level_end", 32'(oLevel), 32'd0);
        frq.delete();

        // Overflow: 6 words while a frame is running; the sixth is dropped.
        push(ovw[0], n0);
        wait_until(n0 + 10);
        for (int i = 1; i < 6; i++) begin
            push(ovw[i], n);
            chk($sformatf("ovf_level%0d", i), 32'(oLevel), 32'(i < 5 ? i : 4));
            chk($sformatf("ovf_flag%0d", i), 32'(oOverflow), 32'(i == 5));
        end
        wait_frames(5, 1200);
        for (int i = 0; i < 5; i++)
            chk_frame($sformatf("ovf%0d", i), i, {8'hA5, ovw[i]});
        repeat (300) tick();
        chk("ovf_no_sixth", 32'(frq.size()), 32'd5);
        chk("ovf_sticky", 32'(oOverflow), 32'd1);
        frq.delete();

        iRst = 1'b1;
        repeat (2) tick();
        iRst = 1'b0;
        tick();
        chk("ovf_cleared", 32'(oOverflow), 32'd0);

        // Push into a full FIFO on the pop edge.
        push(pw[0], n0);
        wait_until(n0 + 10);
        for (int i = 1; i < 5; i++) push(pw[i], n);
        chk("full_level", 32'(oLevel), 32'd4);
        wait_until(n0 + 1 + FLEN);
        iTDC = pw[5]; iValid = 1'b1;
        tick();
        iValid = 1'b0;
        chk("popedge_level", 32'(oLevel), 32'd4);
        chk("popedge_ovf", 32'(oOverflow), 32'd0);
        wait_frames(6, 1400);
        for (int i = 0; i < 6; i++)
            chk_frame($sformatf("pe%0d", i), i, {8'hA5, pw[i]});
        chk("popedge_ovf_end", 32'(oOverflow), 32'd0);
        frq.delete();

        // Reset during DATA of byte 2, with two words still buffered.
        push(24'h13579B, n0);
        push(24'h2468AC, n);
        push(24'h369CF0, n);
        chk("mid_level", 32'(oLevel), 32'd2);
        wait_until(n0 + 1 + 95);
        #2;
        iRst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(oTx), 32'd1);
        chk("mid_rst_busy", 32'(oBusy), 32'd0);
        chk("mid_rst_level", 32'(oLevel), 32'd0);
        repeat (3) tick();
        iRst = 1'b0;
        repeat (200) tick();
        chk("mid_no_partial", 32'(frq.size()), 32'd0);
        push(24'hC0FFEE, n0);
        wait_frames(1, 400);
        chk_frame("after_rst", 0, 32'hA5C0FFEE);
        fa = get_fr(0);
        chk("after_rst_latency", 32'(fa.start), 32'(n0 + 1));
        repeat (400) tick();
        chk("after_rst_discard", 32'(frq.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
